// File: rtl/grid_cursor_nav_if.sv
// Keypad cursor bus: held direction buttons, select pulse and cell mask in;
// cursor position, cell index and accepted-select strobe out.
interface grid_cursor_nav_if #(
    parameter int COLS = 6,
    parameter int ROWS = 4,
    parameter int XW   = 3,
    parameter int YW   = 2,
    parameter int IW   = 5
);
    logic                   dir_up;
    logic                   dir_down;
    logic                   dir_left;
    logic                   dir_right;
    logic                   sel;
    logic [COLS*ROWS-1:0]   dis_mask;
    logic [XW-1:0]          pos_x;
    logic [YW-1:0]          pos_y;
    logic [IW-1:0]          idx;
    logic                   sel_valid;
    logic [IW-1:0]          sel_idx;

    modport master (
        output dir_up, dir_down, dir_left, dir_right, sel, dis_mask,
        input  pos_x, pos_y, idx, sel_valid, sel_idx
    );

    modport slave (
        input  dir_up, dir_down, dir_left, dir_right, sel, dis_mask,
        output pos_x, pos_y, idx, sel_valid, sel_idx
    );
endinterface

// File: rtl/grid_cursor_nav.sv
// Keypad grid cursor with auto-repeat, disabled-cell skipping and select strobe.
// Define GRID_CURSOR_WRAP_EN to let moves wrap around the row/column edge.
module grid_cursor_nav #(
    parameter int COLS          = 6,
    parameter int ROWS          = 4,
    parameter int XW            = 3,
    parameter int YW            = 2,
    parameter int IW            = 5,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 6250000,
    parameter int CW            = 25
) (
    input  logic              clk,
    input  logic              rst,
    grid_cursor_nav_if.slave  bus
);

    localparam int MAXN = (COLS > ROWS) ? COLS : ROWS;
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        D_NONE,
        D_UP,
        D_DOWN,
        D_LEFT,
        D_RIGHT
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_e;

    state_e        state_q, state_d;
    dir_e          dir, dir_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          move;

    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic          sel_valid_q, sel_valid_d;
    logic [IW-1:0] sel_idx_q, sel_idx_d;

    logic [IW-1:0] idx;
    logic          cur_dis;

    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic          found;

    logic [XW-1:0] rel_x;
    logic [YW-1:0] rel_y;
    logic          any_en;

    assign idx     = IW'(pos_y_q) * IW'(COLS) + IW'(pos_x_q);
    assign cur_dis = bus.dis_mask[idx];

    // Fixed priority: up > down > left > right
    always_comb begin
        dir = D_NONE;
        if (bus.dir_up)
            dir = D_UP;
        else if (bus.dir_down)
            dir = D_DOWN;
        else if (bus.dir_left)
            dir = D_LEFT;
        else if (bus.dir_right)
            dir = D_RIGHT;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        move    = 1'b0;
        if (dir == D_NONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_IDLE || dir != dir_q) begin
            move    = 1'b1;
            cnt_d   = '0;
            state_d = S_DELAY;
        end else begin
            unique case (state_q)
                S_DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        move    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REPEAT: begin
                    if (cnt_q == PER_LAST) begin
                        move  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Walk away from the cursor along the move axis; first enabled cell wins.
    always_comb begin
        int            cx;
        int            cy;
        int            lim;
        logic [IW-1:0] ci;
        tgt_x = pos_x_q;
        tgt_y = pos_y_q;
        found = 1'b0;
        cx    = 0;
        cy    = 0;
        ci    = '0;
        lim   = (dir == D_LEFT || dir == D_RIGHT) ? COLS : ROWS;
        for (int k = 1; k < MAXN; k++) begin
            cx = int'(pos_x_q);
            cy = int'(pos_y_q);
            unique case (dir)
                D_UP:    cy = cy - k;
                D_DOWN:  cy = cy + k;
                D_LEFT:  cx = cx - k;
                D_RIGHT: cx = cx + k;
                default: ;
            endcase
`ifdef GRID_CURSOR_WRAP_EN
            if (cx < 0)
                cx = cx + COLS;
            else if (cx >= COLS)
                cx = cx - COLS;
            if (cy < 0)
                cy = cy + ROWS;
            else if (cy >= ROWS)
                cy = cy - ROWS;
`endif
            if (!found && dir != D_NONE && k < lim &&
                cx >= 0 && cx < COLS && cy >= 0 && cy < ROWS) begin
                ci = IW'(cy * COLS + cx);
                if (!bus.dis_mask[ci]) begin
                    found = 1'b1;
                    tgt_x = XW'(cx);
                    tgt_y = YW'(cy);
                end
            end
        end
    end

    // Descending scan so the lowest enabled index is the last to land
    always_comb begin
        logic [IW-1:0] ci;
        rel_x  = '0;
        rel_y  = '0;
        any_en = 1'b0;
        ci     = '0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            for (int x = COLS - 1; x >= 0; x--) begin
                ci = IW'(y * COLS + x);
                if (!bus.dis_mask[ci]) begin
                    any_en = 1'b1;
                    rel_x  = XW'(x);
                    rel_y  = YW'(y);
                end
            end
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (cur_dis) begin
            if (any_en) begin
                pos_x_d = rel_x;
                pos_y_d = rel_y;
            end
        end else if (move && found) begin
            pos_x_d = tgt_x;
            pos_y_d = tgt_y;
        end
    end

    always_comb begin
        sel_valid_d = bus.sel & ~cur_dis;
        sel_idx_d   = sel_valid_d ? idx : sel_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_q       <= D_NONE;
            cnt_q       <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir;
            cnt_q       <= cnt_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            sel_valid_q <= sel_valid_d;
            sel_idx_q   <= sel_idx_d;
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.idx       = idx;
    assign bus.sel_valid = sel_valid_q;
    assign bus.sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_grid_cursor_nav.sv
// Bench for grid_cursor_nav: directed keypad scenarios, then random traffic
// checked against a cell-walking reference model.
module tb_grid_cursor_nav;

    localparam int COLS = 6;
    localparam int ROWS = 4;
    localparam int XW   = 3;
    localparam int YW   = 2;
    localparam int IW   = 5;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int CW   = 4;
    localparam int NC   = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    grid_cursor_nav_if #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .IW(IW)
    ) bus ();

    grid_cursor_nav #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .IW(IW),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    int mx, my, mprev, mage, msv, msi;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int held_dir();
        if (bus.dir_up)    return 1;
        if (bus.dir_down)  return 2;
        if (bus.dir_left)  return 3;
        if (bus.dir_right) return 4;
        return 0;
    endfunction

    function automatic bit cell_on(input int x, input int y);
        return !bus.dis_mask[y * COLS + x];
    endfunction

    // Reference: age counts cycles the same direction has been held.
    task automatic model_cycle();
        int  d, cur, dx, dy, n, tx, ty;
        bit  mv, done, nsv;
        d = held_dir();
        if (rst) begin
            mx = 0; my = 0; mprev = 0; mage = 0; msv = 0; msi = 0;
            return;
        end
        cur = my * COLS + mx;
        if (d == 0 || d != mprev)
            mage = 0;
        else
            mage++;
        mv = (d != 0) && (mage == 0 || mage == RD ||
             (mage > RD && (mage - RD) % RP == 0));
        mprev = d;
        nsv = bus.sel && cell_on(mx, my);
        if (nsv) msi = cur;
        msv = nsv;
        if (!cell_on(mx, my)) begin
            done = 0;
            for (int i = 0; i < NC; i++) begin
                if (!done && !bus.dis_mask[i]) begin
                    done = 1;
                    mx = i % COLS;
                    my = i / COLS;
                end
            end
        end else if (mv) begin
            dx = (d == 4) ? 1 : (d == 3) ? -1 : 0;
            dy = (d == 2) ? 1 : (d == 1) ? -1 : 0;
            n  = (dx != 0) ? COLS : ROWS;
            done = 0;
            for (int k = 1; k < n; k++) begin
                tx = mx + dx * k;
                ty = my + dy * k;
`ifdef GRID_CURSOR_WRAP_EN
                tx = ((tx % COLS) + COLS) % COLS;
                ty = ((ty % ROWS) + ROWS) % ROWS;
`else
                if (tx < 0 || tx >= COLS || ty < 0 || ty >= ROWS)
                    done = 1;
`endif
                if (!done && cell_on(tx, ty)) begin
                    done = 1;
                    mx = tx;
                    my = ty;
                end
            end
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("pos_x", 32'(bus.pos_x), 32'(mx));
        chk("pos_y", 32'(bus.pos_y), 32'(my));
        chk("idx", 32'(bus.idx), 32'(my * COLS + mx));
        chk("sel_valid", 32'(bus.sel_valid), 32'(msv));
        chk("sel_idx", 32'(bus.sel_idx), 32'(msi));
    endtask

    task automatic set_dir(input int d);
        bus.dir_up    = (d == 1);
        bus.dir_down  = (d == 2);
        bus.dir_left  = (d == 3);
        bus.dir_right = (d == 4);
    endtask

    task automatic tap(input int d);
        set_dir(d);
        step();
        set_dir(0);
        step();
    endtask

    task automatic do_reset();
        set_dir(0);
        bus.sel      = 1'b0;
        bus.dis_mask = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        logic [NC-1:0] m;
        set_dir(0);
        bus.sel      = 1'b0;
        bus.dis_mask = '0;

        do_reset();
        chk("rst_x", 32'(bus.pos_x), 0);
        chk("rst_y", 32'(bus.pos_y), 0);
        chk("rst_sv", 32'(bus.sel_valid), 0);
        chk("rst_si", 32'(bus.sel_idx), 0);

        tap(4);
        chk("tap1_x", 32'(bus.pos_x), 1);
        tap(4);
        chk("tap2_x", 32'(bus.pos_x), 2);
        tap(4);
        chk("tap3_x", 32'(bus.pos_x), 3);
        chk("tap3_idx", 32'(bus.idx), 3);
        tap(1);
        chk("up_sat_y", 32'(bus.pos_y), 0);

        do_reset();
        set_dir(2);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) chk("hold_c0_y", 32'(bus.pos_y), 1);
            if (i == 7) chk("hold_c7_y", 32'(bus.pos_y), 1);
            if (i == 8) chk("hold_c8_y", 32'(bus.pos_y), 2);
            if (i == 12) chk("hold_c12_y", 32'(bus.pos_y), 3);
        end
        chk("hold_sat_idx", 32'(bus.idx), 18);
        set_dir(0);
        step();

        do_reset();
        bus.dis_mask = 24'h00000E;
        tap(4);
        chk("skip_x", 32'(bus.pos_x), 4);

        do_reset();
        tap(4);
        tap(4);
        tap(2);
        chk("at21_idx", 32'(bus.idx), 8);
        bus.dis_mask = 24'h000100;
        bus.sel      = 1'b1;
        step();
        chk("reloc_idx", 32'(bus.idx), 0);
        chk("reloc_sv", 32'(bus.sel_valid), 0);
        bus.sel = 1'b0;
        step();

        do_reset();
        tap(2);
        tap(2);
        bus.dir_up    = 1'b1;
        bus.dir_right = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("prio_y", 32'(bus.pos_y), 1);
        chk("prio_x", 32'(bus.pos_x), 0);
        bus.dir_up = 1'b0;
        step();
        chk("switch_x", 32'(bus.pos_x), 1);
        for (int i = 0; i < 9; i++) step();
        set_dir(0);
        step();

        do_reset();
        tap(2);
        tap(2);
        for (int i = 0; i < 5; i++) tap(4);
        chk("at52_idx", 32'(bus.idx), 17);
        tap(4);
`ifdef GRID_CURSOR_WRAP_EN
        chk("edge_x", 32'(bus.pos_x), 0);
`else
        chk("edge_x", 32'(bus.pos_x), 5);
`endif
        bus.sel = 1'b1;
        step();
        bus.sel = 1'b0;
        chk("edge_sv", 32'(bus.sel_valid), 1);
`ifdef GRID_CURSOR_WRAP_EN
        chk("edge_si", 32'(bus.sel_idx), 12);
`else
        chk("edge_si", 32'(bus.sel_idx), 17);
`endif
        step();
        chk("edge_sv_drop", 32'(bus.sel_valid), 0);

        do_reset();
        tap(4);
        bus.dis_mask = '1;
        bus.sel      = 1'b1;
        set_dir(2);
        step();
        chk("alldis_idx", 32'(bus.idx), 1);
        chk("alldis_sv", 32'(bus.sel_valid), 0);
        bus.sel = 1'b0;
        set_dir(0);
        step();

        do_reset();
        set_dir(4);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_x", 32'(bus.pos_x), 1);

        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 22);
                if ($urandom_range(0, 3) == 0) begin
                    {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right}
                        = 4'($urandom_range(0, 15));
                end else begin
                    set_dir(int'($urandom_range(0, 4)));
                end
            end
            hold--;
            bus.sel = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 40) == 0) begin
                for (int b = 0; b < NC; b++)
                    m[b] = ($urandom_range(0, 3) == 0);
                bus.dis_mask = m;
            end else if ($urandom_range(0, 60) == 0) begin
                bus.dis_mask = '0;
            end else if ($urandom_range(0, 300) == 0) begin
                bus.dis_mask = '1;
            end
            rst = ($urandom_range(0, 250) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/grid_cursor_nav.md
Name: grid_cursor_nav

Overview:
- Parametrised cursor for the on-screen calculator keypad grid (COLS x ROWS cells), clocked on the VGA clock.
- Converts held, debounced direction buttons into single-cell moves with auto-repeat.
- Skips cells disabled by a per-cell mask (e.g. hex digits in DEC mode).
- Reports cursor position, row-major cell index, and a one-cycle select strobe to the calculator FSM.

Parameters:
- COLS, 6, grid columns (>=2)
- ROWS, 4, grid rows (>=2)
- XW, 3, pos_x width, >= clog2(COLS)
- YW, 2, pos_y width, >= clog2(ROWS)
- IW, 5, cell index width, >= clog2(COLS*ROWS)
- REPEAT_DELAY, 25000000, cycles a direction is held before the first auto-repeat move
- REPEAT_PERIOD, 6250000, cycles between subsequent auto-repeat moves
- CW, 25, repeat counter width, must hold max(REPEAT_DELAY, REPEAT_PERIOD)

Ports:
- clk  in  1  VGA pixel clock
- rst  in  1  synchronous, active-high reset
- dir_up  in  1  level, button held (debounced)
- dir_down  in  1  level
- dir_left  in  1  level
- dir_right  in  1  level
- sel  in  1  single-cycle select pulse
- dis_mask  in  COLS*ROWS  bit (y*COLS+x)=1 marks cell disabled
- pos_x  out  XW  cursor column, 0 = left
- pos_y  out  YW  cursor row, 0 = top
- idx  out  IW  pos_y*COLS+pos_x, combinational from pos regs
- sel_valid  out  1  one-cycle pulse, select accepted
- sel_idx  out  IW  idx latched at accepted select

Behaviour:
- Reset: pos_x=0, pos_y=0, sel_valid=0, sel_idx=0, repeat FSM IDLE, counter 0.
- Direction resolve: active dir = first asserted of up > down > left > right; at most one move per cycle.
- Up decrements pos_y; down increments pos_y; left decrements pos_x; right increments pos_x.
- Move target: walk cells along the move axis in the move direction; take the first cell with dis_mask=0.
- If no enabled cell before the edge, the cursor holds (saturating mode).
- Moves take effect on pos regs at the clock edge after the triggering cycle.
- Repeat FSM:
  - IDLE: active dir appears -> move now, cnt=0, go DELAY.
  - DELAY: cnt increments each cycle. When cnt==REPEAT_DELAY-1: move, cnt=0, go REPEAT.
  - REPEAT: when cnt==REPEAT_PERIOD-1: move, cnt=0.
  - Any state: no dir -> IDLE, cnt=0.
  - Any state: resolved dir differs from the previous cycle -> move in new dir, cnt=0, go DELAY.
- Disabled current cell: if the current cell's mask bit is 1, the next cycle relocates to the lowest-index enabled cell. This overrides any move that cycle.
- All cells disabled: position holds.
- Select:
  - sel=1 and current cell enabled -> sel_valid=1 next cycle, sel_idx=idx of the cycle sel was high.
  - sel on a disabled cell is dropped.
  - sel simultaneous with a move latches the pre-move idx.
- rst mid-hold: FSM returns to IDLE. A direction still held after rst deasserts counts as a new press and moves on the first post-reset cycle.

Optional Feature:
- Macro: GRID_CURSOR_WRAP_EN.
- Defined: the target search continues past the edge, wrapping to the opposite edge of the same row/column. Example: right from x=COLS-1 searches x=0...
- The search stops when it returns to the start cell; if no other enabled cell is found, the cursor holds.
- Undefined: saturating behaviour as above.

Test Plan (COLS=6, ROWS=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, mask=0 unless stated):
- rst, then tap right for 1 cycle x3 -> pos_x 1,2,3, pos_y=0, idx=3. Tap up at y=0 -> pos_y stays 0.
- Hold down 20 cycles from (0,0) -> moves at cycles 0, 8, 12, 16. pos_y saturates at 3; idx=18.
- dis_mask bits 1..3 set, cursor (0,0), tap right -> pos_x=4 (disabled cells skipped).
- Cursor at (2,1), set dis_mask bit 8 -> next cycle relocates to (0,0) with idx=0. A sel pulse in the mask-set cycle produces no sel_valid.
- Hold right and up together -> only up moves. Release up while right is still held -> immediate right move, counter restarts.
- With GRID_CURSOR_WRAP_EN, cursor (5,2), tap right -> (0,2). Without the macro -> stays at (5,2). Then sel -> sel_valid one cycle with sel_idx=12 (wrap) or 17 (no wrap).
